alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Registered successor to the combinational ALU control decoder: decodes ALUOp/funct into the 4-bit ALU control code and executes the operation on parametrised-width operands.
- Adds valid/ready handshakes, a defined illegal-op response, and an iterative multi-cycle unsigned multiply.
- Sits in the EX stage between the ID/EX pipeline register and EX/MEM.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
MUL_ENABLE, 1, 1 = MULT funct supported; 0 = MULT decodes as illegal

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request this cycle
alu_op  input  3  ALUOp from main control
funct  input  6  instruction funct field
operand_a  input  WIDTH  first operand (rs)
operand_b  input  WIDTH  second operand (rt or immediate)
out_valid  output  1  result registers hold a completed operation
out_ready  input  1  downstream accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB) or product high half nonzero (MULT)
control  output  4  decoded ALU control code of the completed op
illegal  output  1  completed op was an undefined encoding
busy  output  1  multiply in progress

Behaviour:
- Reset: state IDLE; out_valid, result, zero, overflow, illegal, busy, iteration counter = 0; control = 4'b0000. Reset asserted mid-multiply abandons it, no output produced.
- Decode (ALUOp -> control):
  - 000 ADD 0010; 001 SUB 0110; 101 AND 0000; 110 ADD 0010; 111 OR 0001.
  - 010 by funct: 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001; 101010 SLT 0111; 100111 NOR 1100; 100110 XOR 1101; 011000 MULT 1000 (only if MUL_ENABLE).
  - Any other ALUOp/funct combination: illegal, control 1111.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Transfer occurs when in_valid && in_ready.
- Single-cycle ops: result registered; out_valid rises the cycle after acceptance (latency 1).
  - Back-to-back acceptance every cycle while out_ready = 1.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH; overflow = signed overflow.
  - SLT is a signed compare; result is 1 or 0.
  - NOR = ~(a|b); XOR = a^b.
  - Logic ops and SLT set overflow = 0.
- Illegal op: completes with latency 1; result = 0, zero = 1, overflow = 0, illegal = 1, control = 1111. Never stalls.
- MULT (unsigned shift-add):
  - On accept: state IDLE -> MUL; busy = 1; in_ready = 0; operands latched; 2*WIDTH accumulator cleared; counter = 0.
  - Each MUL cycle processes one multiplier bit; counter increments.
  - After WIDTH iterations, state returns to IDLE and out_valid = 1 (latency WIDTH+1 from acceptance).
  - result = low WIDTH bits; overflow = |high WIDTH bits.
- Output hold: while out_valid && !out_ready, result/zero/overflow/control/illegal are stable and in_ready = 0.
- out_valid drops the cycle after out_valid && out_ready unless a new op is accepted that same cycle.
- zero always reflects the registered result.
- Simultaneous drain and accept in one cycle is legal: the new result replaces the old without a gap.
- in_valid while busy is ignored (in_ready = 0); the requester holds the request.

Test Plan:
- Reset release, then ALUOp 010 funct 100000, a = 0x7FFFFFFF, b = 1, out_ready = 1 -> one cycle later out_valid = 1, result = 0x80000000, overflow = 1, control = 0010, zero = 0.
- Stream SUB 5-5, SLT (-1, 1), NOR (0, 0) on consecutive cycles with out_ready = 1 -> three consecutive out_valid cycles; results 0 (zero = 1), 1, 0xFFFFFFFF; in_ready stays 1.
- MULT a = 0x00010000, b = 0x00010000 -> busy for 32 cycles, in_ready = 0; out_valid at cycle 33; result = 0, overflow = 1. Repeat with 6 x 7 -> result = 42, overflow = 0.
- ALUOp 011, and ALUOp 010 funct 000000 -> illegal = 1, control = 1111, result = 0, latency 1. With MUL_ENABLE = 0, MULT -> illegal.
- Backpressure: out_ready = 0 after ADD 2+3 -> result 5 held stable, in_ready = 0 for 4 cycles. Raise out_ready with an ANDI pending -> the next cycle shows the AND result with no bubble.
- Assert reset_n = 0 at multiply iteration 10 -> outputs clear asynchronously; after release, in_ready = 1, out_valid = 0, busy = 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/funct, executes with a registered result,
// valid/ready on both sides, illegal-op response and iterative multiply.
//
// Ports:
//   clock, reset_n         rising-edge clock, async active-low reset
//   in_valid / in_ready    request handshake (alu_op, funct, operands)
//   out_valid / out_ready  result handshake
//   result, zero, overflow, control, illegal  registered completion info
//   busy                   multiply in progress
module alu_exec_unit #(
  parameter int WIDTH      = 32,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [3:0]       control,
  output logic             illegal,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_MUL = 4'b1000;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_XOR = 4'b1101;
  localparam logic [3:0] C_ILL = 4'b1111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               ill_q, ill_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               accept;
  logic [3:0]         dec_ctrl;
  logic [WIDTH-1:0]   add_s;
  logic [WIDTH-1:0]   sub_s;
  logic               add_ov;
  logic               sub_ov;
  logic               slt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ov;
  logic [2*WIDTH-1:0] acc_next;
  logic               mul_last;

  assign in_ready = (state_q == S_IDLE) &&
                    (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_ctrl = C_ILL;
    unique case (alu_op)
      3'b000: dec_ctrl = C_ADD;
      3'b001: dec_ctrl = C_SUB;
      3'b101: dec_ctrl = C_AND;
      3'b110: dec_ctrl = C_ADD;
      3'b111: dec_ctrl = C_OR;
      3'b010: begin
        unique case (funct)
          6'b100000: dec_ctrl = C_ADD;
          6'b100010: dec_ctrl = C_SUB;
          6'b100100: dec_ctrl = C_AND;
          6'b100101: dec_ctrl = C_OR;
          6'b101010: dec_ctrl = C_SLT;
          6'b100111: dec_ctrl = C_NOR;
          6'b100110: dec_ctrl = C_XOR;
          6'b011000: dec_ctrl = MUL_ENABLE ? C_MUL : C_ILL;
          default:   dec_ctrl = C_ILL;
        endcase
      end
      default: dec_ctrl = C_ILL;
    endcase
  end

  assign add_s = operand_a + operand_b;
  assign sub_s = operand_a - operand_b;

  // Signed overflow: operand signs agree (add) or differ (sub)
  // and the sum sign departs from operand_a.
  assign add_ov = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                  (add_s[WIDTH-1] != operand_a[WIDTH-1]);
  assign sub_ov = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                  (sub_s[WIDTH-1] != operand_a[WIDTH-1]);
  assign slt    = $signed(operand_a) < $signed(operand_b);

  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    unique case (dec_ctrl)
      C_ADD: begin
        alu_res = add_s;
        alu_ov  = add_ov;
      end
      C_SUB: begin
        alu_res = sub_s;
        alu_ov  = sub_ov;
      end
      C_AND: alu_res = operand_a & operand_b;
      C_OR:  alu_res = operand_a | operand_b;
      C_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
      C_NOR: alu_res = ~(operand_a | operand_b);
      C_XOR: alu_res = operand_a ^ operand_b;
      default: begin
        alu_res = '0;
        alu_ov  = 1'b0;
      end
    endcase
  end

  // Shift-add: the multiplicand shifts left while the multiplier
  // shifts right, so bit 0 of the multiplier is always the
  // current bit.
  assign acc_next = acc_q +
                    (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    ctrl_d      = ctrl_q;
    ill_d       = ill_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (dec_ctrl == C_MUL) begin
            state_d     = S_MUL;
            busy_d      = 1'b1;
            out_valid_d = 1'b0;
            cnt_d       = '0;
            acc_d       = '0;
            mcand_d     = {{WIDTH{1'b0}}, operand_a};
            mplier_d    = operand_b;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = ~|alu_res;
            ovf_d       = alu_ov;
            ctrl_d      = dec_ctrl;
            ill_d       = (dec_ctrl == C_ILL);
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (mul_last) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          result_d    = acc_next[WIDTH-1:0];
          zero_d      = ~|acc_next[WIDTH-1:0];
          ovf_d       = |acc_next[2*WIDTH-1:WIDTH];
          ctrl_d      = C_MUL;
          ill_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ctrl_q      <= 4'b0000;
      ill_q       <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      ctrl_q      <= ctrl_d;
      ill_q       <= ill_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign control   = ctrl_q;
  assign illegal   = ill_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table, hand-written handshake
// sequences and random ops against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [3:0]  control;
  logic        illegal;
  logic        busy;

  logic        n_in_valid;
  logic        n_in_ready;
  logic [2:0]  n_alu_op;
  logic [5:0]  n_funct;
  logic [7:0]  n_a;
  logic [7:0]  n_b;
  logic        n_out_valid;
  logic [7:0]  n_result;
  logic        n_zero;
  logic        n_overflow;
  logic [3:0]  n_control;
  logic        n_illegal;
  logic        n_busy;

  int tests = 0;
  int fails = 0;

  alu_exec_unit #(.WIDTH(32), .MUL_ENABLE(1'b1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow),
    .control(control), .illegal(illegal), .busy(busy)
  );

  alu_exec_unit #(.WIDTH(8), .MUL_ENABLE(1'b0)) u_dut_nm (
    .clock(clock), .reset_n(reset_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .alu_op(n_alu_op), .funct(n_funct),
    .operand_a(n_a), .operand_b(n_b),
    .out_valid(n_out_valid), .out_ready(1'b1),
    .result(n_result), .zero(n_zero), .overflow(n_overflow),
    .control(n_control), .illegal(n_illegal), .busy(n_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: decode to an operation, then plain integer arithmetic.
  function automatic void model(input logic [2:0] op,
                                input logic [5:0] fn,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] r,
                                output logic ov,
                                output logic [3:0] c,
                                output logic ill);
    longint s;
    logic [63:0] p;
    c = 4'hF;
    if (op == 3'b000 || op == 3'b110) c = 4'h2;
    else if (op == 3'b001) c = 4'h6;
    else if (op == 3'b101) c = 4'h0;
    else if (op == 3'b111) c = 4'h1;
    else if (op == 3'b010) begin
      case (fn)
        6'h20: c = 4'h2;
        6'h22: c = 4'h6;
        6'h24: c = 4'h0;
        6'h25: c = 4'h1;
        6'h2A: c = 4'h7;
        6'h27: c = 4'hC;
        6'h26: c = 4'hD;
        6'h18: c = 4'h8;
        default: c = 4'hF;
      endcase
    end
    r = '0;
    ov = 1'b0;
    ill = 1'b0;
    case (c)
      4'h2, 4'h6: begin
        if (c == 4'h2)
          s = longint'($signed(a)) + longint'($signed(b));
        else
          s = longint'($signed(a)) - longint'($signed(b));
        r = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC: r = ~(a | b);
      4'hD: r = a ^ b;
      4'h8: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
        ov = (p[63:32] != 0);
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic run_op(input string nm,
                        input logic [2:0] op,
                        input logic [5:0] fn,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] er,
                        input logic ez,
                        input logic eo,
                        input logic [3:0] ec,
                        input logic ei);
    int lat;
    bit seen;
    @(negedge clock);
    check({nm, " in_ready"}, in_ready, 1);
    alu_op = op;
    funct = fn;
    operand_a = a;
    operand_b = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 1;
    seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clock);
      if (out_valid) begin
        seen = 1;
      end else begin
        if (lat == 1) begin
          check({nm, " busy"}, busy, 1);
          check({nm, " stall"}, in_ready, 0);
        end
        lat++;
      end
    end
    check({nm, " done"}, seen, 1);
    check({nm, " latency"}, lat, (ec == 4'h8) ? 33 : 1);
    check({nm, " result"}, result, er);
    check({nm, " zero"}, zero, ez);
    check({nm, " overflow"}, overflow, eo);
    check({nm, " control"}, control, ec);
    check({nm, " illegal"}, illegal, ei);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        o;
    logic [3:0]  c;
    logic        i;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [2:0]  ops[8];
    logic [5:0]  fns[9];
    logic [2:0]  rop;
    logic [5:0]  rfn;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mr;
    logic        mo;
    logic [3:0]  mc;
    logic        mi;

    vecs[0]  = '{3'b010, 6'h20, 32'h7FFFFFFF, 32'h1,
                 32'h80000000, 0, 1, 4'h2, 0};
    vecs[1]  = '{3'b001, 6'h00, 32'd5, 32'd5,
                 32'h0, 1, 0, 4'h6, 0};
    vecs[2]  = '{3'b010, 6'h2A, 32'hFFFFFFFF, 32'h1,
                 32'h1, 0, 0, 4'h7, 0};
    vecs[3]  = '{3'b010, 6'h27, 32'h0, 32'h0,
                 32'hFFFFFFFF, 0, 0, 4'hC, 0};
    vecs[4]  = '{3'b010, 6'h26, 32'hF0F0F0F0, 32'hFF00FF00,
                 32'h0FF00FF0, 0, 0, 4'hD, 0};
    vecs[5]  = '{3'b101, 6'h3F, 32'h0000FFFF, 32'h12345678,
                 32'h00005678, 0, 0, 4'h0, 0};
    vecs[6]  = '{3'b111, 6'h00, 32'h000000F0, 32'h00000F00,
                 32'h00000FF0, 0, 0, 4'h1, 0};
    vecs[7]  = '{3'b000, 6'h00, 32'h80000000, 32'h80000000,
                 32'h0, 1, 1, 4'h2, 0};
    vecs[8]  = '{3'b001, 6'h00, 32'h80000000, 32'h1,
                 32'h7FFFFFFF, 0, 1, 4'h6, 0};
    vecs[9]  = '{3'b110, 6'h00, 32'd2, 32'd3,
                 32'd5, 0, 0, 4'h2, 0};
    vecs[10] = '{3'b011, 6'h20, 32'd9, 32'd9,
                 32'h0, 1, 0, 4'hF, 1};
    vecs[11] = '{3'b010, 6'h00, 32'd9, 32'd9,
                 32'h0, 1, 0, 4'hF, 1};
    vecs[12] = '{3'b100, 6'h20, 32'd1, 32'd1,
                 32'h0, 1, 0, 4'hF, 1};
    vecs[13] = '{3'b010, 6'h18, 32'h00010000, 32'h00010000,
                 32'h0, 1, 1, 4'h8, 0};
    vecs[14] = '{3'b010, 6'h18, 32'd6, 32'd7,
                 32'd42, 0, 0, 4'h8, 0};

    ops = '{3'b000, 3'b001, 3'b010, 3'b011,
            3'b100, 3'b101, 3'b110, 3'b111};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A,
            6'h27, 6'h26, 6'h18, 6'h00};

    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_op = '0;
    funct = '0;
    operand_a = '0;
    operand_b = '0;
    n_in_valid = 1'b0;
    n_alu_op = '0;
    n_funct = '0;
    n_a = '0;
    n_b = '0;

    #12;
    check("rst out_valid", out_valid, 0);
    check("rst result", result, 0);
    check("rst zero", zero, 0);
    check("rst overflow", overflow, 0);
    check("rst control", control, 0);
    check("rst illegal", illegal, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      run_op($sformatf("vec%0d", k), vecs[k].op, vecs[k].fn,
             vecs[k].a, vecs[k].b, vecs[k].r, vecs[k].z,
             vecs[k].o, vecs[k].c, vecs[k].i);
    end

    // Streaming: SUB, SLT, NOR accepted on consecutive cycles.
    @(negedge clock);
    alu_op = 3'b001; funct = 6'h00;
    operand_a = 32'd5; operand_b = 32'd5;
    in_valid = 1'b1;
    @(negedge clock);
    check("strm rdy1", in_ready, 1);
    check("strm v1", out_valid, 1);
    check("strm r1", result, 32'h0);
    check("strm z1", zero, 1);
    alu_op = 3'b010; funct = 6'h2A;
    operand_a = 32'hFFFFFFFF; operand_b = 32'd1;
    @(negedge clock);
    check("strm rdy2", in_ready, 1);
    check("strm v2", out_valid, 1);
    check("strm r2", result, 32'h1);
    alu_op = 3'b010; funct = 6'h27;
    operand_a = 32'h0; operand_b = 32'h0;
    @(negedge clock);
    in_valid = 1'b0;
    check("strm rdy3", in_ready, 1);
    check("strm v3", out_valid, 1);
    check("strm r3", result, 32'hFFFFFFFF);
    @(negedge clock);
    check("strm drain", out_valid, 0);

    // Backpressure with a pending ANDI.
    out_ready = 1'b0;
    alu_op = 3'b110; funct = 6'h00;
    operand_a = 32'd2; operand_b = 32'd3;
    in_valid = 1'b1;
    @(negedge clock);
    alu_op = 3'b101; funct = 6'h00;
    operand_a = 32'hFF00FF0F; operand_b = 32'h0F0F00FF;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp v%0d", k), out_valid, 1);
      check($sformatf("bp r%0d", k), result, 32'd5);
      check($sformatf("bp rdy%0d", k), in_ready, 0);
      check($sformatf("bp c%0d", k), control, 4'h2);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1 check("bp release rdy", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    check("bp and v", out_valid, 1);
    check("bp and r", result, 32'h0F00000F);
    check("bp and c", control, 4'h0);

    // Random ops against the model.
    for (int k = 0; k < 300; k++) begin
      rop = ops[$urandom_range(0, 7)];
      rfn = ($urandom_range(0, 9) == 0) ?
            6'($urandom) : fns[$urandom_range(0, 8)];
      if (k % 25 == 0) begin
        rop = 3'b010;
        rfn = 6'h18;
      end
      ra = $urandom;
      rb = $urandom;
      if (k % 5 == 0) rb = ra;
      if (k % 7 == 0) ra = 32'h80000000;
      model(rop, rfn, ra, rb, mr, mo, mc, mi);
      run_op($sformatf("rnd%0d", k), rop, rfn, ra, rb,
             mr, (mr == 0), mo, mc, mi);
    end

    // Reset during multiply iteration 10.
    @(negedge clock);
    alu_op = 3'b010; funct = 6'h18;
    operand_a = 32'd123; operand_b = 32'd456;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1 check("mrst busy before", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    check("mrst busy", busy, 0);
    check("mrst out_valid", out_valid, 0);
    check("mrst in_ready", in_ready, 1);
    check("mrst result", result, 0);
    check("mrst control", control, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("mrst post rdy", in_ready, 1);
    check("mrst post valid", out_valid, 0);
    check("mrst post busy", busy, 0);

    // MUL_ENABLE = 0 instance, 8-bit.
    @(negedge clock);
    n_alu_op = 3'b010; n_funct = 6'h18;
    n_a = 8'd6; n_b = 8'd7;
    n_in_valid = 1'b1;
    @(posedge clock);
    #1 n_in_valid = 1'b0;
    @(negedge clock);
    check("nm mul v", n_out_valid, 1);
    check("nm mul ill", n_illegal, 1);
    check("nm mul c", n_control, 4'hF);
    check("nm mul r", n_result, 0);
    check("nm mul z", n_zero, 1);
    check("nm mul busy", n_busy, 0);
    n_alu_op = 3'b010; n_funct = 6'h20;
    n_a = 8'h7F; n_b = 8'h01;
    n_in_valid = 1'b1;
    @(posedge clock);
    #1 n_in_valid = 1'b0;
    @(negedge clock);
    check("nm add r", n_result, 8'h80);
    check("nm add o", n_overflow, 1);
    check("nm add c", n_control, 4'h2);
    check("nm rdy", n_in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
